// File: rtl/wb_vram_fetch_if.sv
// Wishbone master bus between the VRAM fetcher and the VRAM arbiter.
interface wb_vram_fetch_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [29:0] wbm_addr_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic [31:0] wbm_data_o;
    logic [31:0] wbm_data_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o,
               wbm_sel_o, wbm_we_o, wbm_data_o,
        input  wbm_data_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_addr_o, wbm_cti_o, wbm_bte_o,
               wbm_sel_o, wbm_we_o, wbm_data_o,
        output wbm_data_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_vram_fetch.sv
// Frame-based wishbone burst reader filling a first-word-fall-through pixel FIFO.
module wb_vram_fetch #(
    parameter int unsigned FIFO_AW   = 5,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 frame_start,
    input  logic [11:0]          vram_base,
    input  logic [17:0]          frame_words,
    wb_vram_fetch_if.master      wbm,
    input  logic                 pix_rd,
    output logic [31:0]          pix_data,
    output logic                 pix_empty,
    output logic                 underflow
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned BW    = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_n;
    logic [17:0]          offset, offset_n, remaining, remaining_n, burst_words;
    logic [BW-1:0]        beat, beat_n, len, len_n;
    logic                 cyc_q, cyc_n;
    logic [29:0]          addr_q, addr_n;
    logic [2:0]           cti_q, cti_n;
    logic [3:0]           sel_q;
    logic [CW-1:0]        count, count_n, free, count_after_pop;
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
    logic [31:0]          mem [DEPTH];
    logic [31:0]          head_n;
    logic                 underflow_n, push, pop, last_beat;

    assign push            = wbm.wbm_stb_o & wbm.wbm_ack_i & ~frame_start;
    assign pop             = pix_rd & ~pix_empty;
    assign free            = CW'(DEPTH) - count;
    assign burst_words     = (remaining < 18'(BURST_LEN)) ? remaining : 18'(BURST_LEN);
    assign last_beat       = (beat == len - BW'(1));
    assign count_after_pop = count - CW'(pop);

    assign wbm.wbm_cyc_o  = cyc_q;
    assign wbm.wbm_stb_o  = cyc_q;
    assign wbm.wbm_addr_o = addr_q;
    assign wbm.wbm_cti_o  = cti_q;
    assign wbm.wbm_sel_o  = sel_q;
    assign wbm.wbm_bte_o  = 2'b00;
    assign wbm.wbm_we_o   = 1'b0;
    assign wbm.wbm_data_o = 32'h0;

    // Burst sequencer: next state, next bus outputs and frame bookkeeping
    always_comb begin
        state_n     = state;
        offset_n    = offset;
        remaining_n = remaining;
        beat_n      = beat;
        len_n       = len;
        cyc_n       = cyc_q;
        addr_n      = addr_q;
        cti_n       = cti_q;
        if (frame_start) begin
            state_n     = IDLE;
            offset_n    = '0;
            remaining_n = frame_words;
            beat_n      = '0;
            cyc_n       = 1'b0;
            cti_n       = 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (remaining != 18'd0) && (free >= CW'(BURST_LEN))) begin
                        state_n = BURST;
                        len_n   = BW'(burst_words);
                        beat_n  = '0;
                        cyc_n   = 1'b1;
                        addr_n  = {vram_base, offset};
                        cti_n   = (burst_words == 18'd1) ? 3'b111 : 3'b010;
                    end
                end
                BURST: begin
                    if (push) begin
                        offset_n    = offset + 18'd1;
                        remaining_n = remaining - 18'd1;
                        beat_n      = beat + BW'(1);
                        addr_n      = {vram_base, offset_n};
                        if (last_beat) begin
                            state_n = IDLE;
                            cyc_n   = 1'b0;
                            cti_n   = 3'b000;
                        end else begin
                            cti_n = (beat_n == len - BW'(1)) ? 3'b111 : 3'b010;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping: occupancy, read pointer, registered head word, underflow flag
    always_comb begin
        count_n     = count;
        rd_ptr_n    = rd_ptr;
        head_n      = pix_data;
        underflow_n = underflow;
        if (frame_start) begin
            count_n     = '0;
            rd_ptr_n    = '0;
            underflow_n = 1'b0;
        end else begin
            if (pix_rd && pix_empty) underflow_n = 1'b1;
            if (pop) rd_ptr_n = rd_ptr + FIFO_AW'(1);
            count_n = count_after_pop + CW'(push);
            if (count_after_pop == '0) begin
                if (push) head_n = wbm.wbm_data_i;
            end else if (pop) begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    // State, bus output and FIFO control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            offset    <= '0;
            remaining <= '0;
            beat      <= '0;
            len       <= '0;
            cyc_q     <= 1'b0;
            addr_q    <= '0;
            cti_q     <= 3'b000;
            sel_q     <= 4'h0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pix_data  <= '0;
            pix_empty <= 1'b1;
            underflow <= 1'b0;
        end else begin
            state     <= state_n;
            offset    <= offset_n;
            remaining <= remaining_n;
            beat      <= beat_n;
            len       <= len_n;
            cyc_q     <= cyc_n;
            addr_q    <= addr_n;
            cti_q     <= cti_n;
            sel_q     <= cyc_n ? 4'hF : 4'h0;
            count     <= count_n;
            rd_ptr    <= rd_ptr_n;
            pix_data  <= head_n;
            pix_empty <= (count_n == '0);
            underflow <= underflow_n;
            if (frame_start)  wr_ptr <= '0;
            else if (push)    wr_ptr <= wr_ptr + FIFO_AW'(1);
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr] <= wbm.wbm_data_i;
    end
endmodule

// File: doc/wb_vram_fetch.md
# wb_vram_fetch

Wishbone burst reader that streams a frame of pixel words from VRAM into a first-word-fall-through FIFO for the graphic pixel stage. It sits between the VRAM wishbone bus (as master) and the graphic pixel generator, which pops one 32-bit word per request. Fetching is frame-based: the block restarts from the VRAM base on every frame pulse and keeps the FIFO topped up with fixed-length incrementing bursts.

## Interface
- FIFO_AW, 5, FIFO address width; depth = 2^FIFO_AW words.
- BURST_LEN, 8, maximum beats per burst; power of two, ≤ 2^(FIFO_AW-1).
- clk  in  1  main clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets).
- en  in  1  fetch enable; low blocks new bursts.
- frame_start  in  1  one-cycle pulse marking the start of a frame.
- vram_base  in  12  frame base, byte address = {vram_base, 20'h0}.
- frame_words  in  18  words per frame; sampled on frame_start.
- wbm_cyc_o, wbm_stb_o  out  1  wishbone cycle/strobe.
- wbm_addr_o  out  30  word address [31:2].
- wbm_cti_o  out  3  010 incrementing, 111 last beat.
- wbm_bte_o  out  2  always 00 (linear).
- wbm_sel_o  out  4  4'hF during a cycle, else 0.
- wbm_we_o  out  1  always 0.
- wbm_data_o  out  32  always 0.
- wbm_data_i  in  32  read data.
- wbm_ack_i  in  1  beat acknowledge.
- pix_rd  in  1  pop request from pixel stage.
- pix_data  out  32  FIFO head word (valid when pix_empty=0).
- pix_empty  out  1  FIFO empty.
- underflow  out  1  sticky: pop attempted while empty.

## Operation
- State machine: IDLE, BURST.
- Internal: offset (18 b word offset), remaining (18 b words left in frame), beat (burst beat counter), FIFO count (FIFO_AW+1 b).
- IDLE → BURST when en=1, remaining>0, free = 2^FIFO_AW − count ≥ BURST_LEN. Burst length L = min(BURST_LEN, remaining), latched at entry.
- BURST: cyc=stb=1, sel=4'hF, addr = {vram_base, 18'h0} + offset. cti=010 except on beat L-1, where cti=111. Each ack: push wbm_data_i, offset+1, remaining−1, beat+1, addr advances. After the ack of beat L-1: cyc/stb/sel/cti go to 0 and state → IDLE; at least one idle cycle separates bursts.
- Ack with stb=0 is ignored.
- Pop: pix_rd with pix_empty=0 removes the head; simultaneous push and pop leave count unchanged. pix_rd with pix_empty=1 does not change the FIFO and sets underflow.
- frame_start (highest priority after reset): FIFO flushed, offset=0, remaining=frame_words, underflow=0, state → IDLE, cyc/stb dropped; an ack in the same cycle is discarded and no push occurs.
- en falling during BURST: the current burst completes, then no new burst starts.
- Offset wraps modulo 2^18 and stays within the 1 MB window.
- vram_base must be stable for a whole frame.

## Timing
- Reset (rst=0 at an edge): cyc, stb, we = 0; addr = 0; cti = 0; bte = 0; sel = 0; data_o = 0; state IDLE; offset = 0; remaining = 0; FIFO empty; pix_empty = 1; underflow = 0; pix_data = 0.
- All wishbone outputs are registered. The burst-start decision is made in cycle t, and cyc/stb are high from edge t+1.
- After frame_start is sampled at edge k, the earliest cyc=1 is at edge k+1.
- Write latency: data acked at edge e is visible on pix_data at edge e if the FIFO was empty (pix_empty falls at edge e).
- Read latency: a pop at edge e exposes the next word at edge e.
- Zero-wait-state slave: an L-beat burst occupies L cycles, followed by one idle cycle.

## Test plan
- Reset, then frame_start with vram_base=12'h001, frame_words=20, en=1, zero-wait slave, no pops -> three bursts with addr starting 30'h0004_0000, lengths 8, 8, 4; cti=111 on the 8th, 16th and 20th beats; 20 words in FIFO in order; bus then idle.
- frame_words=64, no pops -> after 32 words cyc stays 0; pop 8 words -> exactly one more 8-beat burst starting at offset 32.
- Slave inserting 2 wait cycles per beat -> addr holds until each ack; data order preserved; no extra pushes.
- Pop on empty FIFO -> underflow=1, pix_empty stays 1; next frame_start -> underflow=0.
- frame_start after 3 acks of a burst -> cyc=0 at the next edge, pix_empty=1, new burst at offset 0; an ack coinciding with frame_start is not pushed.
- rst=0 asserted mid-burst -> all outputs at reset values at the next edge; with en=1 and no frame_start, no further bursts (remaining=0).
